// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment scan driver:
//   - code_t   : 5-bit glyph code (one per digit)
//   - glyph_t  : 7-bit segment pattern, bit 6 = a ... bit 0 = g, active-high
//   - phase_t  : scan slot phase (BLANK / SHOW)
//   - GLY_*    : named glyph codes above the hex range
//   - glyph_decode() : 32-entry code -> segment map
// -----------------------------------------------------------------------------
package seg7_pkg;

  typedef logic [4:0] code_t;
  typedef logic [6:0] glyph_t;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_t;

  localparam code_t GLY_ZERO  = 5'd0;
  localparam code_t GLY_BLANK = 5'd16;
  localparam code_t GLY_DASH  = 5'd17;
  localparam code_t GLY_H     = 5'd18;
  localparam code_t GLY_L     = 5'd19;
  localparam code_t GLY_P     = 5'd20;
  localparam code_t GLY_U     = 5'd21;
  localparam code_t GLY_R     = 5'd22;
  localparam code_t GLY_N     = 5'd23;
  localparam code_t GLY_O     = 5'd24;

  localparam glyph_t SEG_OFF = 7'b000_0000;

  // Codes 25..31 are unassigned and deliberately render as blank.
  function automatic glyph_t glyph_decode(input code_t code);
    glyph_t g;
    case (code)
      5'd0:      g = 7'b111_1110;
      5'd1:      g = 7'b011_0000;
      5'd2:      g = 7'b110_1101;
      5'd3:      g = 7'b111_1001;
      5'd4:      g = 7'b011_0011;
      5'd5:      g = 7'b101_1011;
      5'd6:      g = 7'b101_1111;
      5'd7:      g = 7'b111_0000;
      5'd8:      g = 7'b111_1111;
      5'd9:      g = 7'b111_1011;
      5'd10:     g = 7'b111_0111;
      5'd11:     g = 7'b001_1111;
      5'd12:     g = 7'b100_1110;
      5'd13:     g = 7'b011_1101;
      5'd14:     g = 7'b100_1111;
      5'd15:     g = 7'b100_0111;
      GLY_BLANK: g = 7'b000_0000;
      GLY_DASH:  g = 7'b000_0001;
      GLY_H:     g = 7'b011_0111;
      GLY_L:     g = 7'b000_1110;
      GLY_P:     g = 7'b110_0111;
      GLY_U:     g = 7'b011_1110;
      GLY_R:     g = 7'b000_0101;
      GLY_N:     g = 7'b001_0101;
      GLY_O:     g = 7'b001_1101;
      default:   g = SEG_OFF;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// -----------------------------------------------------------------------------
// seg7_scan_timer
// Slot/digit timebase for the scan driver. Owns the slot counter (cnt), the
// digit index (idx) and the slot phase.
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous reset, active low
//   idx_o         out  digit currently being scanned
//   phase_o       out  PH_BLANK for the first BLANK_CYC clocks of a slot
//   frame_end_o   out  high in the last clock of the last digit's slot
//   frame_start_o out  high in the first clock of digit 0's slot
// -----------------------------------------------------------------------------
module seg7_scan_timer
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int CLK_DIV   = 1000,
  parameter int BLANK_CYC = 8,
  parameter int IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [IDX_W-1:0] idx_o,
  output phase_t           phase_o,
  output logic             frame_end_o,
  output logic             frame_start_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  // With no blanking interval the very first slot clock is already visible.
  localparam phase_t PHASE_RST = (BLANK_CYC > 0) ? PH_BLANK : PH_SHOW;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  phase_t           phase_q, phase_d;
  logic             slot_end_s;

  assign slot_end_s = (cnt_q == CNT_LAST);

  // Next-state for slot counter, digit index and phase.
  always_comb begin
    cnt_d   = cnt_q + CNT_ONE;
    idx_d   = idx_q;
    if (slot_end_s) begin
      cnt_d = CNT_ZERO;
      if (idx_q == IDX_LAST) begin
        idx_d = IDX_ZERO;
      end else begin
        idx_d = idx_q + IDX_ONE;
      end
    end else begin
      idx_d = idx_q;
    end
    // Phase is registered alongside cnt so it always describes cnt_q.
    if (cnt_d < CNT_BLANK) begin
      phase_d = PH_BLANK;
    end else begin
      phase_d = PH_SHOW;
    end
  end

  // Timebase state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= CNT_ZERO;
      idx_q   <= IDX_ZERO;
      phase_q <= PHASE_RST;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
    end
  end

  assign idx_o         = idx_q;
  assign phase_o       = phase_q;
  assign frame_end_o   = slot_end_s && (idx_q == IDX_LAST);
  assign frame_start_o = (cnt_q == CNT_ZERO) && (idx_q == IDX_ZERO);

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed, double-buffered driver for a DIGITS-wide 7-segment display.
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous reset, active low
//   load        in   strobe: capture din/dp_in into the shadow buffer
//   din         in   5-bit glyph code per digit, digit k at din[5k+4:5k]
//   dp_in       in   decimal-point request per digit
//   seg         out  segments a..g (seg[6]=a)
//   dp          out  decimal point of the active digit
//   an          out  one-hot digit enable
//   pending     out  shadow buffer holds data not yet committed
//   frame_start out  one-clock pulse at the start of digit 0's slot
// Shadow data is committed to the display only at the frame end, so a frame
// never mixes old and new digits. All outputs come straight from flops;
// ACTIVE_LOW inverts seg/dp/an at those flops.
// Build option: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zeros at
// commit (digit 0 always kept, dp untouched).
// -----------------------------------------------------------------------------
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int CLK_DIV    = 1000,
  parameter int BLANK_CYC  = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [5*DIGITS-1:0]   din,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  pending,
  output logic                  frame_start
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic INV = (ACTIVE_LOW != 0);

  localparam logic [5*DIGITS-1:0] CODES_BLANK = {DIGITS{GLY_BLANK}};
  localparam logic [DIGITS-1:0]   DIG_ZERO    = {DIGITS{1'b0}};
  localparam logic [DIGITS-1:0]   DIG_ONE     = DIGITS'(1);
  localparam logic [DIGITS-1:0]   AN_IDLE     = {DIGITS{INV}};
  localparam glyph_t              SEG_IDLE    = {7{INV}};

  // Timebase
  logic [IDX_W-1:0] idx_s;
  phase_t           phase_s;
  logic             frame_end_s;
  logic             frame_start_s;

  seg7_scan_timer #(
    .DIGITS    (DIGITS),
    .CLK_DIV   (CLK_DIV),
    .BLANK_CYC (BLANK_CYC),
    .IDX_W     (IDX_W)
  ) u_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .idx_o         (idx_s),
    .phase_o       (phase_s),
    .frame_end_o   (frame_end_s),
    .frame_start_o (frame_start_s)
  );

  // Buffers
  logic [5*DIGITS-1:0] shadow_q;
  logic [DIGITS-1:0]   shadow_dp_q;
  logic [5*DIGITS-1:0] disp_q;
  logic [DIGITS-1:0]   disp_dp_q;
  logic                pending_q;

  logic                commit_s;
  logic [5*DIGITS-1:0] commit_src_s;
  logic [DIGITS-1:0]   commit_dp_s;
  logic [5*DIGITS-1:0] commit_codes_s;

  // A load in the frame-end cycle bypasses the shadow so it lands this frame.
  assign commit_s     = frame_end_s && (pending_q || load);
  assign commit_src_s = load ? din   : shadow_q;
  assign commit_dp_s  = load ? dp_in : shadow_dp_q;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic seen_nz_s;

  // Blank zeros that have only zeros above them; digit 0 is never touched.
  always_comb begin
    commit_codes_s = commit_src_s;
    seen_nz_s      = 1'b0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (commit_src_s[5*k +: 5] != GLY_ZERO) begin
        seen_nz_s = 1'b1;
      end else if (!seen_nz_s) begin
        commit_codes_s[5*k +: 5] = GLY_BLANK;
      end else begin
        commit_codes_s[5*k +: 5] = commit_src_s[5*k +: 5];
      end
    end
  end
`else
  assign commit_codes_s = commit_src_s;
`endif

  // Shadow capture, frame-end commit and pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= CODES_BLANK;
      shadow_dp_q <= DIG_ZERO;
      disp_q      <= CODES_BLANK;
      disp_dp_q   <= DIG_ZERO;
      pending_q   <= 1'b0;
    end else begin
      if (load) begin
        shadow_q    <= din;
        shadow_dp_q <= dp_in;
      end else begin
        shadow_q    <= shadow_q;
        shadow_dp_q <= shadow_dp_q;
      end
      if (commit_s) begin
        disp_q    <= commit_codes_s;
        disp_dp_q <= commit_dp_s;
        pending_q <= 1'b0;
      end else if (load) begin
        pending_q <= 1'b1;
      end else begin
        pending_q <= pending_q;
      end
    end
  end

  // Active digit selection
  code_t  cur_code_s;
  logic   cur_dp_s;
  glyph_t cur_glyph_s;

  assign cur_code_s  = disp_q[5*idx_s +: 5];
  assign cur_dp_s    = disp_dp_q[idx_s];
  assign cur_glyph_s = glyph_decode(cur_code_s);

  logic [6:0]        seg_q;
  logic              dp_q;
  logic [DIGITS-1:0] an_q;
  logic              frame_start_q;

  // Output registers; polarity applied here so pins never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q         <= SEG_IDLE;
      dp_q          <= INV;
      an_q          <= AN_IDLE;
      frame_start_q <= 1'b0;
    end else begin
      if (phase_s == PH_SHOW) begin
        seg_q <= cur_glyph_s ^ SEG_IDLE;
        dp_q  <= cur_dp_s ^ INV;
        an_q  <= (DIG_ONE << idx_s) ^ AN_IDLE;
      end else begin
        seg_q <= SEG_IDLE;
        dp_q  <= INV;
        an_q  <= AN_IDLE;
      end
      frame_start_q <= frame_start_s;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign pending     = pending_q;
  assign frame_start = frame_start_q;

endmodule
